// File: rtl/boolean_sweep_checker.sv
// Built-in self-test for a 4-input Boolean function: sweeps all 16 vectors,
// samples F after a settle window and records mismatches against EXPECTED_TT.
module boolean_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED_TT   = 16'hA5A5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic        drv_a,
  output logic        drv_b,
  output logic        drv_c,
  output logic        drv_d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic        err_valid,
  output logic [15:0] mismatch_map
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  settle_q;
  logic [3:0]  vec_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [4:0]  err_count_q;
  logic [3:0]  first_err_q;
  logic        err_valid_q;
  logic [15:0] map_q;

  logic        miss_d;
  logic [4:0]  err_count_d;
  logic [15:0] map_d;

  // Result updates for the vector currently being sampled; used only on the sample edge.
  always_comb begin
    miss_d        = (f_in != EXPECTED_TT[idx_q]);
    err_count_d   = err_count_q + 5'(miss_d);
    map_d         = map_q;
    map_d[idx_q]  = map_q[idx_q] | miss_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      settle_q    <= '0;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
      err_valid_q <= 1'b0;
      map_q       <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= RUN;
            idx_q       <= '0;
            settle_q    <= '0;
            vec_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            err_valid_q <= 1'b0;
            map_q       <= '0;
          end
        end
        RUN: begin
          if (settle_q != SETTLE_LIM) begin
            settle_q <= settle_q + 8'd1;
          end else begin
            settle_q    <= '0;
            err_count_q <= err_count_d;
            map_q       <= map_d;
            if (miss_d && !err_valid_q) begin
              first_err_q <= idx_q;
              err_valid_q <= 1'b1;
            end
            // Last vector finishes the sweep; pass must see its own mismatch too.
            if (idx_q == 4'hF) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              vec_q   <= '0;
              pass_q  <= (err_count_d == 5'd0);
            end else begin
              idx_q <= idx_q + 4'd1;
              vec_q <= idx_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {drv_a, drv_b, drv_c, drv_d} = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;
  assign err_valid     = err_valid_q;
  assign mismatch_map  = map_q;

endmodule

// File: doc/boolean_sweep_checker.md
Name: boolean_sweep_checker

Overview:
- Exhaustive stimulus generator and response checker for the 4-input Boolean function block (inputs A,B,C,D; output F).
- It drives all 16 input vectors in order, waits a programmable settle time, and samples F.
- Each sample is compared against a parameterised expected truth table; the block reports pass/fail, error count, first failing index and a mismatch map.
- It sits on the initiator side of the function block, as a built-in self-test (BIST) wrapper.

Parameters:
- SETTLE_CYCLES, 2: extra cycles each vector is held before F is sampled. Legal range 0..255.
- EXPECTED_TT, 16'hA5A5: expected F per vector index {A,B,C,D}. Bit i is the expected F for index i. The default encodes F = B XNOR D.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to begin a sweep.
- f_in  input  1  F returned from the function under test.
- drv_a  output  1  stimulus A (MSB of index).
- drv_b  output  1  stimulus B.
- drv_c  output  1  stimulus C.
- drv_d  output  1  stimulus D (LSB of index).
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; results valid.
- pass  output  1  done and zero mismatches.
- err_count  output  5  number of mismatching vectors, 0..16.
- first_err_idx  output  4  index of the lowest mismatching vector.
- err_valid  output  1  at least one mismatch recorded.
- mismatch_map  output  16  bit i set when vector i mismatched.

Behaviour:
- Clocking and reset:
  - Single clock domain; every output is registered.
  - Reset is synchronous and active-low: rst_n is sampled on the clk rising edge.
  - Reset values: all outputs 0; state IDLE; idx 0; settle counter 0.
  - rst_n low mid-sweep aborts the sweep. Next cycle all outputs are at reset values and no partial results are retained.
- State machine (IDLE, RUN, DONE):
  - IDLE: drv_* = 0, busy = 0, done = 0. On start = 1, go to RUN. Clear err_count, mismatch_map, err_valid, first_err_idx and pass. Set idx = 0, settle = 0, busy = 1.
  - RUN: {drv_a,drv_b,drv_c,drv_d} = idx. Each vector is held for exactly SETTLE_CYCLES+1 cycles.
    - While settle < SETTLE_CYCLES: settle increments each cycle.
    - On the edge where settle == SETTLE_CYCLES, sample f_in. If f_in != EXPECTED_TT[idx]:
      - set mismatch_map[idx];
      - increment err_count;
      - if err_valid = 0, load first_err_idx = idx and set err_valid.
    - Then settle returns to 0 and idx increments.
    - The sample edge of idx 15 moves to DONE instead of wrapping. idx does not wrap to 0 inside a sweep.
  - DONE: busy = 0, done = 1, drv_* = 0, pass = (err_count == 0). Results hold until the next start or reset. start in DONE behaves as start in IDLE: clear results and begin a new sweep the next cycle.
- Handshake and latency:
  - start is sampled at edge k, so busy = 1 and vector 0 are visible after edge k.
  - done rises after edge k + 16*(SETTLE_CYCLES+1): 48 cycles at the default, 16 cycles with SETTLE_CYCLES = 0.
  - busy and done are never high together.
  - start while busy is ignored: no restart and no effect on results.
  - pass and first_err_idx are meaningful only while done = 1. pass = 0 whenever done = 0.
- Width and arithmetic rules:
  - err_count is 5 bits, so 16 mismatches fit without saturation.
  - The settle counter is 8 bits.
  - The comparison is a 1-bit inequality. An X or Z on f_in is treated as is; no filtering.

Test Plan:
1. Reset: hold rst_n = 0 for 3 cycles with start toggling -> all outputs 0, drv_* = 0, no sweep starts.
2. Golden loopback with a correct XNOR model, SETTLE_CYCLES = 2, start pulse at edge k -> busy for 48 cycles, each {drv_a..d} equals idx for 3 cycles in order 0..15, then done = 1, pass = 1, err_count = 0, mismatch_map = 16'h0000, err_valid = 0.
3. f_in tied to 1 -> done, pass = 0, err_count = 8, mismatch_map = 16'h5A5A, first_err_idx = 1, err_valid = 1.
4. f_in driven by B&D only (missing ~B&~D term) -> err_count = 4, mismatch_map = 16'h0505, first_err_idx = 0, pass = 0.
5. Control sequence:
   - Extra start pulses while busy -> ignored; done still arrives at k+48.
   - start from DONE -> results cleared next cycle and a new sweep runs.
   - rst_n = 0 at cycle 20 of a sweep -> next cycle all outputs are 0 and state is IDLE.
   - A fresh start after reset -> a full 48-cycle sweep.
6. SETTLE_CYCLES = 0 with golden model -> each vector held 1 cycle, done after exactly 16 cycles, pass = 1.
